// File: rtl/aes_key_sched.sv
// Sequential AES-128/192/256 key schedule: one schedule word per cycle from an
// 8-word sliding window, streaming 128-bit round keys over a valid/ready handshake.
module aes_key_sched #(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         start_ready,
  input  logic [255:0] key,
  input  logic [1:0]   key_len,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy,
  output logic         err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [5:0]   i_q, i_d;
  logic [3:0]   rnext_q, rnext_d;
  logic [2:0]   kpos_q, kpos_d;   // i mod Nk
  logic [7:0]   rcon_q, rcon_d;   // Rcon(i/Nk) for the next i mod Nk == 0 word
  logic [31:0]  win_q [8];
  logic [31:0]  win_d [8];
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         rk_last_q, rk_last_d;
  logic         rk_valid_q, rk_valid_d;
  logic         err_q, err_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (k != 0) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic        legal, accept, gen_en, ld_en, xfer;
  logic [3:0]  mode_nk, mode_nr;
  logic [5:0]  total_words;
  logic [2:0]  prev_slot, back_slot, base;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp;

  always_comb begin
    legal   = 1'b0;
    mode_nk = 4'd4;
    mode_nr = 4'd10;
    case (key_len)
      2'd0: legal = 1'b1;
      2'd1: begin legal = SUPPORT_192; mode_nk = 4'd6; mode_nr = 4'd12; end
      2'd2: begin legal = SUPPORT_256; mode_nk = 4'd8; mode_nr = 4'd14; end
      default: legal = 1'b0;
    endcase
  end

  assign accept      = start && (state_q == StIdle);
  assign total_words = {nr_q, 2'b00} + 6'd4;
  assign xfer        = rk_valid_q && rk_ready;
  // Stop generating once 8 words are buffered past the next key to load.
  assign gen_en = (state_q == StRun) && (i_q < total_words) &&
                  ({1'b0, i_q} < ({1'b0, rnext_q, 2'b00} + 7'd8));
  assign ld_en  = (state_q == StRun) && (rnext_q <= nr_q) &&
                  (({rnext_q, 2'b00} + 6'd3) < i_q) && (!rk_valid_q || rk_ready);

  assign prev_slot = i_q[2:0] - 3'd1;
  assign back_slot = i_q[2:0] - nk_q[2:0];
  assign w_prev    = win_q[prev_slot];
  assign w_back    = win_q[back_slot];
  assign sub_in    = (kpos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_out   = sub_word(sub_in);
  assign base      = {rnext_q[0], 2'b00};

  always_comb begin
    if (kpos_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if ((nk_q == 4'd8) && (kpos_q == 3'd4)) begin
      temp = sub_out;
    end else begin
      temp = w_prev;
    end
  end

  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    rnext_d    = rnext_q;
    kpos_d     = kpos_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_last_d  = rk_last_q;
    rk_valid_d = rk_valid_q;
    err_d      = 1'b0;

    if (accept) begin
      if (legal) begin
        state_d = StRun;
        nk_d    = mode_nk;
        nr_d    = mode_nr;
        i_d     = {2'b00, mode_nk};
        rnext_d = 4'd0;
        kpos_d  = 3'd0;
        rcon_d  = 8'h01;
        // Slots past Nk hold don't-care words that generation overwrites first.
        for (int j = 0; j < 8; j++) win_d[j] = key[255 - 32*j -: 32];
      end else begin
        err_d = 1'b1;
      end
    end

    if (gen_en) begin
      win_d[i_q[2:0]] = w_back ^ temp;
      i_d             = i_q + 6'd1;
      kpos_d          = (kpos_q == nk_q[2:0] - 3'd1) ? 3'd0 : kpos_q + 3'd1;
      if (kpos_q == 3'd0) rcon_d = xtime(rcon_q);
    end

    if (ld_en) begin
      rk_d       = {win_q[base], win_q[base + 3'd1], win_q[base + 3'd2], win_q[base + 3'd3]};
      rk_idx_d   = rnext_q;
      rk_last_d  = (rnext_q == nr_q);
      rk_valid_d = 1'b1;
      rnext_d    = rnext_q + 4'd1;
    end else if (xfer) begin
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end

    if ((state_q == StRun) && xfer && rk_last_q) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      i_q        <= '0;
      rnext_q    <= '0;
      kpos_q     <= '0;
      rcon_q     <= 8'h01;
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
      rk_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      rnext_q    <= rnext_d;
      kpos_q     <= kpos_d;
      rcon_q     <= rcon_d;
      for (int j = 0; j < 8; j++) win_q[j] <= win_d[j];
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_last_q  <= rk_last_d;
      rk_valid_q <= rk_valid_d;
      err_q      <= err_d;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q == StRun);
  assign rk_valid    = rk_valid_q;
  assign rk          = rk_q;
  assign rk_idx      = rk_idx_q;
  assign rk_last     = rk_last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: array-based FIPS-197 expansion model with a log/antilog
// S-box, a per-cycle round-key monitor, and directed mode/error/reset scenarios.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         start_ready, rk_valid, rk_last, busy, err;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  logic         start2;
  logic         start_ready2, rk_valid2, rk_last2, busy2, err2;
  logic [127:0] rk2;
  logic [3:0]   rk_idx2;

  aes_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .key(key),
    .key_len(key_len), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy), .err(err)
  );

  aes_key_sched #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .start_ready(start_ready2), .key(key),
    .key_len(key_len), .rk_valid(rk_valid2), .rk_ready(1'b1), .rk(rk2), .rk_idx(rk_idx2),
    .rk_last(rk_last2), .busy(busy2), .err(err2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   exp_t [256];
  int           log_t [256];
  logic [127:0] model_rk [16];
  int           model_nr;

  bit           mon_on = 1'b0;
  int           exp_idx, n_xfer, acc_cyc;
  bit           held;
  logic [127:0] held_rk;
  int           pres_cyc [16];

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    inv = (x == 8'h00) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
    for (int b = 0; b < 8; b++)
      s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
    return s;
  endfunction

  function automatic logic [31:0] tb_sub(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  task automatic build_model(input logic [255:0] k, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [7:0]  rc [16];
    logic [31:0] t;
    int nk;
    nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    model_nr = nk + 6;
    rc[1] = 8'h01;
    for (int j = 2; j < 16; j++) rc[j] = tb_xt(rc[j-1]);
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (model_nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = tb_sub({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = tb_sub(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      model_rk[r] = (r <= model_nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Round-key monitor: order, content, rk_last, stability under stall, no drops.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rk_valid) begin
        if (exp_idx > model_nr) begin
          checks++; failures++;
          $display("FAIL extra_key got_idx=%0d want=none", rk_idx);
        end else begin
          if (!held) pres_cyc[exp_idx] = cyc;
          else check("rk_stable", rk, held_rk);
          check("rk_idx", {124'h0, rk_idx}, exp_idx);
          check("rk_value", rk, model_rk[exp_idx]);
          check("rk_last", {127'h0, rk_last}, {127'h0, exp_idx == model_nr});
          if (rk_ready) begin exp_idx++; n_xfer++; held = 1'b0; end
          else begin held = 1'b1; held_rk = rk; end
        end
      end else if (held) begin
        checks++; failures++;
        $display("FAIL rk_dropped got_valid=0 want_valid=1");
        held = 1'b0;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_start_ready"}, {127'h0, start_ready}, 128'h1);
    check({tag, "_rk_valid"}, {127'h0, rk_valid}, 128'h0);
    check({tag, "_rk"}, rk, 128'h0);
    check({tag, "_rk_idx"}, {124'h0, rk_idx}, 128'h0);
    check({tag, "_rk_last"}, {127'h0, rk_last}, 128'h0);
    check({tag, "_busy"}, {127'h0, busy}, 128'h0);
    check({tag, "_err"}, {127'h0, err}, 128'h0);
  endtask

  // Called at posedge+1 with the DUT idle; mode 0 = always ready, 1 = random with stalls.
  task automatic run_sched(input logic [255:0] k, input logic [1:0] kl, input int mode,
                           input bit inject);
    int guard, stall;
    bit did3, did7;
    build_model(k, kl);
    exp_idx = 0; n_xfer = 0; held = 1'b0; mon_on = 1'b1;
    guard = 0; stall = 0; did3 = 0; did7 = 0;
    start = 1'b1; key = k; key_len = kl; rk_ready = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0; key = ~k; key_len = 2'd3;
    check("run_busy", {127'h0, busy}, 128'h1);
    check("run_start_ready", {127'h0, start_ready}, 128'h0);
    while (exp_idx <= model_nr && guard < 2000) begin
      if (inject && guard == 11) begin
        check("ignored_start_err", {127'h0, err}, 128'h0);
        check("ignored_start_busy", {127'h0, busy}, 128'h1);
      end
      start = inject && (guard == 10);
      if (mode == 1) begin
        if (stall > 0) begin rk_ready = 1'b0; stall--; end
        else if (exp_idx == 3 && !did3) begin did3 = 1; stall = 19; rk_ready = 1'b0; end
        else if (exp_idx == 7 && !did7) begin did7 = 1; stall = 19; rk_ready = 1'b0; end
        else rk_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    mon_on = 1'b0;
    if (guard >= 2000) begin
      checks++; failures++;
      $display("FAIL timeout got_keys=%0d want_keys=%0d", n_xfer, model_nr + 1);
    end
    check("end_start_ready", {127'h0, start_ready}, 128'h1);
    check("end_busy", {127'h0, busy}, 128'h0);
    check("end_rk_valid", {127'h0, rk_valid}, 128'h0);
    check("xfer_count", n_xfer, model_nr + 1);
    rk_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] p;
    int guard;
    bit saw;
    p = 8'h01;
    for (int j = 0; j < 255; j++) begin
      exp_t[j] = p; log_t[p] = j; p = p ^ tb_xt(p);
    end
    log_t[0] = 0; exp_t[255] = 8'h01;

    // Pin the model to published vectors.
    build_model(K128, 2'd0);
    check("model128_rk0", model_rk[0], K128[255:128]);
    check("model128_rk10", model_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    build_model(K192, 2'd1);
    check("model192_rk12", model_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    build_model(K256, 2'd2);
    check("model256_rk1", model_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("model256_rk14", model_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    build_model(K2B, 2'd0);
    check("model2b_rk10", model_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rst = 1'b1; start = 1'b0; start2 = 1'b0; key = '0; key_len = 2'd0; rk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_sched(K128, 2'd0, 0, 1'b1);
    check("latency_rk0", pres_cyc[0] - acc_cyc, 1);
    check("latency_rk10", pres_cyc[10] - acc_cyc, 41);
    run_sched(K192, 2'd1, 0, 1'b0);
    run_sched(K256, 2'd2, 0, 1'b0);
    run_sched(K2B, 2'd0, 1, 1'b0);

    // Illegal key_len = 3.
    start = 1'b1; key = K128; key_len = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal3_err", {127'h0, err}, 128'h1);
    check("illegal3_start_ready", {127'h0, start_ready}, 128'h1);
    @(posedge clk); #1;
    check("illegal3_err_pulse", {127'h0, err}, 128'h0);
    saw = 1'b0;
    repeat (6) begin @(posedge clk); #1; saw |= rk_valid | busy; end
    check("illegal3_no_keys", {127'h0, saw}, 128'h0);

    // AES-256 start on an instance without AES-256 support.
    start2 = 1'b1; key_len = 2'd2;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("no256_err", {127'h0, err2}, 128'h1);
    check("no256_start_ready", {127'h0, start_ready2}, 128'h1);
    @(posedge clk); #1;
    check("no256_err_pulse", {127'h0, err2}, 128'h0);
    saw = 1'b0;
    repeat (6) begin @(posedge clk); #1; saw |= rk_valid2 | busy2 | ~start_ready2; end
    check("no256_no_keys", {127'h0, saw}, 128'h0);

    // Reset mid AES-256 with rk5 held unaccepted.
    build_model(K256, 2'd2);
    exp_idx = 0; n_xfer = 0; held = 1'b0; mon_on = 1'b1;
    start = 1'b1; key = K256; key_len = 2'd2; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(rk_valid && rk_idx == 4'd5) && guard < 200) begin @(posedge clk); #1; guard++; end
    rk_ready = 1'b0;
    check("hold_rk5_reached", {127'h0, guard < 200}, 128'h1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_rk5_idx", {124'h0, rk_idx}, 128'h5);
    check("hold_rk5_valid", {127'h0, rk_valid}, 128'h1);
    mon_on = 1'b0; held = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("midrst");
    rst = 1'b0; rk_ready = 1'b1;
    @(posedge clk); #1;
    run_sched(K128, 2'd0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
